// File: rtl/wb_stage.sv
// Writeback stage: 2-entry retire buffer, register-file write port, pending-write scoreboard.
// Optional retired-instruction counter enabled by defining WB_RETIRE_CNT_EN.
module wb_stage #(
  parameter int REGISTER_WIDTH         = 64,
  parameter int REGISTERNO_WIDTH       = 5,
  parameter int INSTRUCTION_NAME_WIDTH = 12*8,
  parameter int PEND_CNT_WIDTH         = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_enable,
  input  logic                              in_update_rd_bool,
  input  logic                              in_mm_load_bool,
  input  logic [REGISTER_WIDTH-1:0]         in_mdata,
  input  logic [REGISTER_WIDTH-1:0]         in_alu_result,
  input  logic [REGISTERNO_WIDTH-1:0]       in_rd_regno,
  input  logic [INSTRUCTION_NAME_WIDTH-1:0] in_opcode_name,
  output logic                              out_ready,
  input  logic                              in_rf_ready,
  output logic                              out_rf_wr_en,
  output logic [REGISTERNO_WIDTH-1:0]       out_rf_wr_regno,
  output logic [REGISTER_WIDTH-1:0]         out_rf_wr_data,
  input  logic                              in_issue_valid,
  input  logic [REGISTERNO_WIDTH-1:0]       in_issue_regno,
  output logic [31:0]                       out_busy_bits,
  output logic                              out_issue_stall,
  output logic [63:0]                       out_retired
);

  localparam int NREG = 1 << REGISTERNO_WIDTH;

  typedef struct packed {
    logic [REGISTER_WIDTH-1:0]   data;
    logic [REGISTERNO_WIDTH-1:0] regno;
    logic                        wr;
  } entry_t;

  entry_t slot [2];
  entry_t head;
  entry_t incoming;
  logic   wptr;
  logic   rptr;
  logic [1:0] count;
  logic   push;
  logic   pop;
  logic   inc;
  logic [NREG-1:0] up;
  logic [NREG-1:0] dn;
  logic [PEND_CNT_WIDTH-1:0] cnt [NREG];
  logic   unused_opcode;

  // opcode name is trace-only and is not carried through the buffer
  assign unused_opcode = ^in_opcode_name;

  assign out_ready = (count < 2'd2);
  assign push      = in_enable & out_ready;
  assign pop       = (count != 2'd0) & in_rf_ready;
  assign head      = slot[rptr];

  always_comb begin
    incoming       = '0;
    incoming.data  = in_mm_load_bool ? in_mdata : in_alu_result;
    incoming.regno = in_rd_regno;
    incoming.wr    = in_update_rd_bool & (in_rd_regno != '0);
  end

  always_ff @(posedge clk) begin
    if (push) slot[wptr] <= incoming;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) wptr <= ~wptr;
      if (pop)  rptr <= ~rptr;
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_rf_wr_en    <= 1'b0;
      out_rf_wr_regno <= '0;
      out_rf_wr_data  <= '0;
    end else begin
      out_rf_wr_en <= pop & head.wr;
      if (pop & head.wr) begin
        out_rf_wr_regno <= head.regno;
        out_rf_wr_data  <= head.data;
      end
    end
  end

  assign out_issue_stall = in_issue_valid & (cnt[in_issue_regno] == '1);
  assign inc = in_issue_valid & (in_issue_regno != '0) & ~out_issue_stall;

  always_comb begin
    up = '0;
    dn = '0;
    if (inc)          up[in_issue_regno]  = 1'b1;
    if (out_rf_wr_en) dn[out_rf_wr_regno] = 1'b1;
  end

  // decrement lands on the edge where the register file commits
  always_ff @(posedge clk) begin
    for (int r = 0; r < NREG; r++) begin
      if (reset || r == 0)
        cnt[r] <= '0;
      else if (up[r] & ~dn[r])
        cnt[r] <= cnt[r] + PEND_CNT_WIDTH'(1);
      else if (dn[r] & ~up[r] & (cnt[r] != '0))
        cnt[r] <= cnt[r] - PEND_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && out_rf_wr_en)
      assert (cnt[out_rf_wr_regno] != '0);
  end

  always_comb begin
    out_busy_bits = '0;
    for (int r = 0; r < NREG; r++)
      out_busy_bits[r] = |cnt[r];
  end

`ifdef WB_RETIRE_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)    out_retired <= '0;
    else if (pop) out_retired <= out_retired + 64'd1;
  end
`else
  assign out_retired = '0;
`endif

endmodule
